// File: rtl/sayeh_mem_pkg.sv
// Shared types and defaults for the memory access controller.
package sayeh_mem_pkg;
  localparam int ADDR_W_DEF  = 10;
  localparam int DATA_W_DEF  = 16;
  localparam int TIMEOUT_DEF = 15;
  localparam int CNT_W       = 8;

  typedef enum logic [1:0] {ST_IDLE, ST_ISSUE, ST_WAIT, ST_DONE} state_t;
endpackage

// File: rtl/mem_timeout_cnt.sv
// Saturating access-timeout counter; expired flags the edge on which the
// count reaches LIMIT.
module mem_timeout_cnt
  import sayeh_mem_pkg::*;
#(
  parameter int LIMIT = TIMEOUT_DEF
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic en,
  output logic expired
);
  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                                  cnt <= '0;
    else if (clear)                              cnt <= '0;
    else if (en && cnt != CNT_W'(LIMIT))         cnt <= cnt + 1'b1;
  end

  assign expired = en && (cnt == CNT_W'(LIMIT - 1));
endmodule

// File: rtl/mem_access_ctrl.sv
// CPU-to-memory access controller: IDLE/ISSUE/WAIT/DONE handshake with timeout.
// Optional posted writes: define MEM_ACCESS_CTRL_POSTED_WR_EN.
module mem_access_ctrl
  import sayeh_mem_pkg::*;
#(
  parameter int ADDR_W  = ADDR_W_DEF,
  parameter int DATA_W  = DATA_W_DEF,
  parameter int TIMEOUT = TIMEOUT_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req,
  input  logic              req_we,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              ack,
  output logic              err,
  output logic [DATA_W-1:0] rdata,
  output logic              busy,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_din,
  input  logic [DATA_W-1:0] mem_dout,
  output logic              mem_nd,
  output logic              mem_we,
  input  logic              mem_rdy
);
`ifdef MEM_ACCESS_CTRL_POSTED_WR_EN
  localparam logic POSTED = 1'b1;
`else
  localparam logic POSTED = 1'b0;
`endif

  state_t state_q, state_d;
  logic we_lat_q, we_lat_d;
  logic [ADDR_W-1:0] addr_d;
  logic [DATA_W-1:0] din_d, rdata_d;
  logic nd_d, we_d, ack_d, err_d;
  logic expired, fin, tmo;

  mem_timeout_cnt #(.LIMIT(TIMEOUT)) u_tmo (
    .clk     (clk),
    .rst_n   (rst_n),
    .clear   (state_q == ST_IDLE && req),
    .en      (state_q == ST_ISSUE || state_q == ST_WAIT),
    .expired (expired)
  );

  // Timeout can only fire from WAIT since ISSUE lasts one cycle and TIMEOUT >= 2.
  assign fin = (state_q == ST_ISSUE && mem_rdy) ||
               (state_q == ST_WAIT && (mem_rdy || expired));
  assign tmo = (state_q == ST_WAIT) && !mem_rdy && expired;

  always_comb begin
    state_d  = state_q;
    we_lat_d = we_lat_q;
    addr_d   = mem_addr;
    din_d    = mem_din;
    nd_d     = mem_nd;
    we_d     = mem_we;
    ack_d    = 1'b0;
    err_d    = 1'b0;
    rdata_d  = rdata;
    case (state_q)
      ST_IDLE: if (req) begin
        state_d  = ST_ISSUE;
        we_lat_d = req_we;
        addr_d   = req_addr;
        din_d    = req_wdata;
        nd_d     = !req_we;
        we_d     = req_we;
        if (POSTED && req_we) begin
          ack_d   = 1'b1;
          rdata_d = '0;
        end
      end
      ST_ISSUE: state_d = mem_rdy ? ST_DONE : ST_WAIT;
      ST_WAIT:  if (fin) state_d = ST_DONE;
      ST_DONE:  state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
    if (fin) begin
      nd_d    = 1'b0;
      we_d    = 1'b0;
      // A posted write was already acked; its completion is silent unless it times out.
      ack_d   = !(POSTED && we_lat_q);
      err_d   = tmo;
      rdata_d = (tmo || we_lat_q) ? '0 : mem_dout;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      we_lat_q <= 1'b0;
      mem_addr <= '0;
      mem_din  <= '0;
      mem_nd   <= 1'b0;
      mem_we   <= 1'b0;
      ack      <= 1'b0;
      err      <= 1'b0;
      rdata    <= '0;
      busy     <= 1'b0;
    end else begin
      state_q  <= state_d;
      we_lat_q <= we_lat_d;
      mem_addr <= addr_d;
      mem_din  <= din_d;
      mem_nd   <= nd_d;
      mem_we   <= we_d;
      ack      <= ack_d;
      err      <= err_d;
      rdata    <= rdata_d;
      busy     <= (state_d != ST_IDLE);
    end
  end
endmodule
